// File: rtl/gcm_pkg.sv
// Shared types and constants for the GCM receive-side tag check.
package gcm_pkg;

    localparam int unsigned TAG_MIN_BYTES = 12;
    localparam int unsigned BLK_BYTES     = 16;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StCompare,
        StRelease,
        StDone
    } tag_chk_state_t;

    typedef struct packed {
        logic [127:0] data;
        logic [4:0]   len;
    } blk_t;

    // Ones in the leading n bytes (bit 127 downward), zeros below; n above 16 saturates.
    function automatic logic [127:0] lead_bytes_mask(input logic [4:0] n);
        logic [127:0] m;
        m = '0;
        for (int unsigned i = 0; i < BLK_BYTES; i++) begin
            if (i < 32'(n)) begin
                m[127-8*i -: 8] = 8'hff;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/gcm_blk_fifo.sv
// Synchronous FIFO of decrypted blocks with push/pop, occupancy count and one-cycle flush.
module gcm_blk_fifo
    import gcm_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  blk_t             wdata,
    input  logic             pop,
    output blk_t             rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    blk_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/gcm_tag_check.sv
// GCM receive-side authentication gate: buffers plaintext, releases it only on tag match.
// Optional TAG_TRUNC_EN adds the Tag_len port and compares only the leading Tag_len bytes.
module gcm_tag_check
    import gcm_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] Tag_in,
    input  logic [31:0]  Block_total,
`ifdef TAG_TRUNC_EN
    input  logic [4:0]   Tag_len,
`endif
    input  logic [127:0] PText_in,
    input  logic [4:0]   PText_byte_len,
    input  logic         PText_valid,
    input  logic [127:0] AuthTag,
    input  logic         AuthTag_valid,
    output logic [127:0] Out_data,
    output logic [4:0]   Out_byte_len,
    output logic         Out_valid,
    input  logic         Out_ready,
    output logic         Out_last,
    output logic         Pass,
    output logic         Fail,
    output logic         Done
);

    tag_chk_state_t   state_q, state_d;
    logic [127:0]     tag_q, tag_d;
    logic [127:0]     atag_q, atag_d;
    logic [31:0]      total_q, total_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             ovf_q, ovf_d;

    logic             fifo_flush, fifo_push, fifo_pop;
    logic             fifo_empty, fifo_full;
    logic [CNT_W-1:0] fifo_cnt;
    blk_t             fifo_head;
    blk_t             fifo_wdata;

    logic [127:0]     cmp_mask;
    logic             len_ok;
    logic             tag_diff;
    logic             count_ok;
    logic             match;

`ifdef TAG_TRUNC_EN
    logic [4:0]       tlen_q, tlen_d;

    assign cmp_mask = lead_bytes_mask(tlen_q);
    assign len_ok   = (tlen_q >= 5'(TAG_MIN_BYTES)) && (tlen_q <= 5'(BLK_BYTES));
`else
    assign cmp_mask = '1;
    assign len_ok   = 1'b1;
`endif

    // Full-width XOR reduction: every bit contributes, no early exit on first difference.
    assign tag_diff = |((tag_q ^ atag_q) & cmp_mask);
    assign count_ok = (32'(fifo_cnt) == total_q);
    assign match    = !tag_diff && count_ok && !ovf_q && len_ok;

    assign fifo_wdata = '{data: PText_in, len: PText_byte_len};

    gcm_blk_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .count (fifo_cnt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        atag_d     = atag_q;
        total_d    = total_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        ovf_d      = ovf_q;
        fifo_flush = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
`ifdef TAG_TRUNC_EN
        tlen_d     = tlen_q;
`endif
        // start from any state begins a fresh message; mid-message it is an abort.
        if (start) begin
            state_d    = StCollect;
            tag_d      = Tag_in;
            total_d    = Block_total;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            ovf_d      = 1'b0;
            fifo_flush = 1'b1;
`ifdef TAG_TRUNC_EN
            tlen_d     = Tag_len;
`endif
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (PText_valid) begin
                        if (fifo_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            fifo_push = 1'b1;
                        end
                    end
                    if (AuthTag_valid) begin
                        atag_d  = AuthTag;
                        state_d = StCompare;
                    end
                end
                StCompare: begin
                    if (match) begin
                        pass_d  = 1'b1;
                        state_d = fifo_empty ? StDone : StRelease;
                    end else begin
                        fail_d     = 1'b1;
                        fifo_flush = 1'b1;
                        state_d    = StDone;
                    end
                end
                StRelease: begin
                    if (Out_valid && Out_ready) begin
                        fifo_pop = 1'b1;
                        if (fifo_cnt == CNT_W'(1)) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                StIdle: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            tag_q   <= '0;
            atag_q  <= '0;
            total_q <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            atag_q  <= atag_d;
            total_q <= total_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef TAG_TRUNC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlen_q <= '0;
        end else begin
            tlen_q <= tlen_d;
        end
    end
`endif

    // Outputs decode registered state only, so they stay stable while the consumer stalls.
    assign Out_valid    = (state_q == StRelease) && !fifo_empty;
    assign Out_data     = Out_valid ? (fifo_head.data & lead_bytes_mask(fifo_head.len)) : '0;
    assign Out_byte_len = Out_valid ? fifo_head.len : '0;
    assign Out_last     = Out_valid && (fifo_cnt == CNT_W'(1));
    assign Pass         = pass_q;
    assign Fail         = fail_q;
    assign Done         = (state_q == StDone);

endmodule

// File: tb/tb_gcm_tag_check.sv
// Scoreboard bench for gcm_tag_check: random and directed messages against a byte-level model.
module tb_gcm_tag_check;

    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] Tag_in;
    logic [31:0]  Block_total;
`ifdef TAG_TRUNC_EN
    logic [4:0]   Tag_len;
`endif
    logic [127:0] PText_in;
    logic [4:0]   PText_byte_len;
    logic         PText_valid;
    logic [127:0] AuthTag;
    logic         AuthTag_valid;
    logic [127:0] Out_data;
    logic [4:0]   Out_byte_len;
    logic         Out_valid;
    logic         Out_ready;
    logic         Out_last;
    logic         Pass;
    logic         Fail;
    logic         Done;

    always #5 clk = ~clk;

    gcm_tag_check #(
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .Tag_in         (Tag_in),
        .Block_total    (Block_total),
`ifdef TAG_TRUNC_EN
        .Tag_len        (Tag_len),
`endif
        .PText_in       (PText_in),
        .PText_byte_len (PText_byte_len),
        .PText_valid    (PText_valid),
        .AuthTag        (AuthTag),
        .AuthTag_valid  (AuthTag_valid),
        .Out_data       (Out_data),
        .Out_byte_len   (Out_byte_len),
        .Out_valid      (Out_valid),
        .Out_ready      (Out_ready),
        .Out_last       (Out_last),
        .Pass           (Pass),
        .Fail           (Fail),
        .Done           (Done)
    );

    typedef struct {
        logic [127:0] data;
        logic [4:0]   len;
        logic         last;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] blk_data[$];
    int           blk_len[$];
    int           msg_tlen;
    int           checks = 0;
    int           errors = 0;
    int           ov_cycles = 0;
    int           ov_base;
    bit           rdy_rand = 0;
    bit           rdy_force = 1;
    bit           abort_pending = 0;

    localparam logic [127:0] T1 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] T2 = 128'hab6e47d42cec13bdf53a67b21257bddf;
    localparam logic [127:0] T4 = 128'h5bc94fbc3221a5db94fae95ae7121a47;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Keep the first len bytes (MSB-first), zero the rest.
    function automatic logic [127:0] trim(input logic [127:0] d, input int len);
        logic [127:0] keep;
        keep = ~((128'h1 << (8 * (16 - len))) - 128'h1);
        return d & keep;
    endfunction

    function automatic bit tag_model(input logic [127:0] rx, input logic [127:0] comp,
                                     input int tlen);
        if (tlen < 12 || tlen > 16) return 1'b0;
        return ((rx ^ comp) >> (8 * (16 - tlen))) == 128'h0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Consumer ready driver.
    initial begin
        Out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            Out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability and masking.
    exp_t         mon_e;
    bit           done_due = 0;
    bit           stall_prev = 0;
    logic [127:0] prev_data;
    logic [4:0]   prev_len;
    logic         prev_last;

    always @(negedge clk) begin
        if (rst) begin
            done_due   = 0;
            stall_prev = 0;
        end else begin
            if (done_due) begin
                chk("done_after_last", 128'(Done), 128'(1));
                done_due = 0;
            end
            if (stall_prev) begin
                chk("stall_valid", 128'(Out_valid), 128'(1));
                chk("stall_data", Out_data, prev_data);
                chk("stall_len", 128'(Out_byte_len), 128'(prev_len));
                chk("stall_last", 128'(Out_last), 128'(prev_last));
            end
            if (!Out_valid) chk("mask_zero", Out_data, 128'h0);
            if (Out_valid) ov_cycles++;
            if (Out_valid && Out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_release actual=%h required=none", Out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", Out_data, mon_e.data);
                    chk("out_len", 128'(Out_byte_len), 128'(mon_e.len));
                    chk("out_last", 128'(Out_last), 128'(mon_e.last));
                    if (mon_e.last) done_due = 1;
                end
            end
            stall_prev = Out_valid && !Out_ready && !start;
            prev_data  = Out_data;
            prev_len   = Out_byte_len;
            prev_last  = Out_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All stimulus tasks start and end just after a rising edge.
    task automatic run_msg(input logic [127:0] rx, input logic [127:0] comp, input int total,
                           input bit coincide, input bit junk, input bit abort_mid);
        int n;
        bit exp_pass;
        bit got;
        n = blk_data.size();
        exp_pass = tag_model(rx, comp, msg_tlen) && (n == total) && (n <= DEPTH);
        exp_q.delete();
        if (exp_pass) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back('{trim(blk_data[i], blk_len[i]), 5'(blk_len[i]), i == n - 1});
            end
        end
        start       = 1'b1;
        Tag_in      = rx;
        Block_total = 32'(total);
`ifdef TAG_TRUNC_EN
        Tag_len     = 5'(msg_tlen);
`endif
        ov_base = ov_cycles;
        step();
        start = 1'b0;
        if (abort_pending) begin
            @(negedge clk);
            #1;
            chk("abort_no_valid", 128'(Out_valid), 128'(0));
            chk("abort_no_done", 128'(Done), 128'(0));
            chk("abort_pass_clr", 128'(Pass), 128'(0));
            abort_pending = 0;
            step();
        end
        for (int i = 0; i < n; i++) begin
            PText_valid    = 1'b1;
            PText_in       = blk_data[i];
            PText_byte_len = 5'(blk_len[i]);
            if (coincide && i == n - 1) break;
            step();
            PText_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) step();
        end
        AuthTag       = comp;
        AuthTag_valid = 1'b1;
        step();
        AuthTag_valid  = 1'b0;
        PText_valid    = junk;
        PText_in       = rnd128();
        PText_byte_len = 5'd16;
        step();
        PText_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("pass_t2", 128'(Pass), 128'(exp_pass));
        chk("fail_t2", 128'(Fail), 128'(!exp_pass));
        if (exp_pass && n > 0) begin
            chk("first_valid_t2", 128'(Out_valid), 128'(1));
            chk("no_early_done", 128'(Done), 128'(0));
            if (abort_mid) begin
                got = 0;
                for (int c = 0; c < 200; c++) begin
                    if (exp_q.size() < n) begin
                        got = 1;
                        break;
                    end
                    @(negedge clk);
                    #1;
                end
                chk("abort_progress", 128'(got), 128'(1));
                rdy_rand  = 0;
                rdy_force = 0;
                step();
                step();
                chk("abort_held", 128'(Out_valid), 128'(1));
                abort_pending = 1;
                return;
            end
            got = 0;
            for (int c = 0; c < 2000; c++) begin
                if (Done) begin
                    got = 1;
                    break;
                end
                @(negedge clk);
                #1;
            end
            chk("done_seen", 128'(got), 128'(1));
            chk("drained", 128'(exp_q.size()), 128'(0));
        end else begin
            chk("done_t2", 128'(Done), 128'(1));
            chk("no_release", 128'(ov_cycles - ov_base), 128'(0));
        end
        exp_q.delete();
        step();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_valid"}, 128'(Out_valid), 128'(0));
        chk({name, "_data"}, Out_data, 128'h0);
        chk({name, "_len"}, 128'(Out_byte_len), 128'(0));
        chk({name, "_last"}, 128'(Out_last), 128'(0));
        chk({name, "_pass"}, 128'(Pass), 128'(0));
        chk({name, "_fail"}, 128'(Fail), 128'(0));
        chk({name, "_done"}, 128'(Done), 128'(0));
    endtask

    task automatic rand_blocks(input int n);
        blk_data.delete();
        blk_len.delete();
        for (int i = 0; i < n; i++) begin
            blk_data.push_back(rnd128());
            blk_len.push_back($urandom_range(1, 16));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int total;
        logic [127:0] rx;
        logic [127:0] comp;
        rst            = 1'b1;
        start          = 1'b0;
        Tag_in         = '0;
        Block_total    = '0;
`ifdef TAG_TRUNC_EN
        Tag_len        = 5'd16;
`endif
        PText_in       = '0;
        PText_byte_len = '0;
        PText_valid    = 1'b0;
        AuthTag        = '0;
        AuthTag_valid  = 1'b0;
        msg_tlen       = 16;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        step();
        rst = 1'b0;
        step();

        // Empty message.
        blk_data.delete();
        blk_len.delete();
        run_msg(T1, T1, 0, 0, 0, 0);

        // Single zero block.
        blk_data.push_back(128'h0);
        blk_len.push_back(16);
        run_msg(T2, T2, 1, 0, 0, 0);

        // Four-block partial message with a stalling consumer.
        blk_data.delete();
        blk_len.delete();
        blk_data.push_back(128'hd9313225f88406e5a55909c5aff5269a);
        blk_data.push_back(128'h86a7a9531534f7da2e4c303d8a318a72);
        blk_data.push_back(128'h1c3c0c95956809532fcf0e2449a6b525);
        blk_data.push_back(128'hb16aedf5aa0de657ba637b3900000000);
        blk_len.push_back(16);
        blk_len.push_back(16);
        blk_len.push_back(16);
        blk_len.push_back(12);
        rdy_rand = 1;
        run_msg(T4, T4, 4, 0, 0, 0);

        // Same blocks, computed tag bit 0 flipped.
        rdy_rand  = 0;
        rdy_force = 1;
        run_msg(T4, T4 ^ 128'h1, 4, 0, 0, 0);

        // Overflow: DEPTH+1 blocks, matching tags, total at DEPTH.
        rand_blocks(DEPTH + 1);
        run_msg(T4, T4, DEPTH, 0, 0, 0);

        // Abort a release with a new start, then complete the new message.
        rand_blocks(6);
        rdy_rand = 1;
        run_msg(T2, T2, 6, 0, 0, 1);
        rdy_rand  = 0;
        rdy_force = 1;
        rand_blocks(3);
        run_msg(T1, T1, 3, 1, 1, 0);

        // Reset in the middle of a release.
        rand_blocks(5);
        rdy_rand = 1;
        run_msg(T4, T4, 5, 0, 0, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        exp_q.delete();
        abort_pending = 0;
        step();
        rst       = 1'b0;
        rdy_rand  = 0;
        rdy_force = 1;
        step();
        rand_blocks(2);
        run_msg(T2, T2, 2, 0, 0, 0);

`ifdef TAG_TRUNC_EN
        rand_blocks(1);
        msg_tlen = 12;
        run_msg(T4, T4 ^ 128'h00000000_00000000_00000000_deadbeef, 1, 0, 0, 0);
        msg_tlen = 11;
        run_msg(T4, T4, 1, 0, 0, 0);
        msg_tlen = 16;
`endif

        for (int k = 0; k < 30; k++) begin
            n = ($urandom_range(0, 7) == 0) ? DEPTH + int'($urandom_range(1, 2))
                                            : int'($urandom_range(0, DEPTH));
            total = n;
            if ($urandom_range(0, 5) == 0) total = (n > 0 && $urandom_range(0, 1) == 1) ? n - 1
                                                                                         : n + 1;
            if (n > DEPTH && $urandom_range(0, 1) == 1) total = DEPTH;
            rx   = rnd128();
            comp = rx;
            if ($urandom_range(0, 3) == 0) comp = rx ^ (128'h1 << $urandom_range(0, 127));
`ifdef TAG_TRUNC_EN
            msg_tlen = int'($urandom_range(11, 17));
            if ($urandom_range(0, 2) == 0) comp = comp ^ 128'(32'($urandom));
`endif
            rand_blocks(n);
            rdy_rand = 1'($urandom_range(0, 1));
            run_msg(rx, comp, total, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
